k051962_plane_shifter: RTL

Pixel-serialisation stage directly downstream of the k052109 plane address generator. It takes the 32-bit graphics ROM word fetched for each tile of the fix, A and B planes, together with the tile attribute latched at fetch time. It serialises each word into 4-bit pixels, applies the per-plane 3-bit fine horizontal scroll (ZA/ZB), and resolves plane priority into a single 8-bit colour index per pixel for the palette stage.

---
 rtl/k051962_pkg.sv | 23 ++
 rtl/k051962_plane_window.sv | 65 ++++++
 rtl/k051962_plane_shifter.sv | 87 ++++++++
 3 files changed

// File: rtl/k051962_pkg.sv
// Shared types and helpers for the k051962 pixel serialiser.
package k051962_pkg;
  localparam int NPLANES = 3;

  localparam logic [1:0] PL_FIX     = 2'd0;
  localparam logic [1:0] PL_A       = 2'd1;
  localparam logic [1:0] PL_B       = 2'd2;
  localparam logic [1:0] LAYER_NONE = 2'd3;

  typedef logic [3:0] pix4_t;
  typedef pix4_t [7:0] row_t;

  // Planar row to chunky pixels: pixel i takes bit (7-i) of every bitplane.
  function automatic row_t unpack_row(input logic [31:0] d, input logic flip);
    row_t r;
    int   src;
    for (int i = 0; i < 8; i++) begin
      src = flip ? 7 - i : i;
      for (int k = 0; k < 4; k++) r[i][k] = d[8*k + 7 - src];
    end
    return r;
  endfunction
endpackage

// File: rtl/k051962_plane_window.sv
// One plane's tile pipeline (pend -> cur -> prev) and fine-scroll pixel pick.
module plane_window
  import k051962_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       line_start,
  input  logic       boundary,
  input  logic       load,
  input  row_t       row,
  input  logic [3:0] pal,
  input  logic [2:0] fine,
  input  logic [2:0] phase,
  output pix4_t      pix,
  output logic [3:0] pix_pal,
  output logic       miss
);
  row_t       pend, cur, prev;
  logic [3:0] pend_pal, cur_pal, prev_pal;
  logic       fresh;

  pix4_t [15:0] win;
  logic  [3:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      cur      <= '0;
      prev     <= '0;
      pend_pal <= '0;
      cur_pal  <= '0;
      prev_pal <= '0;
      fresh    <= 1'b0;
      miss     <= 1'b0;
    end else if (ce) begin
      // Line start blanks the window but keeps a prefetched tile for the first boundary.
      if (line_start) begin
        cur      <= '0;
        prev     <= '0;
        cur_pal  <= '0;
        prev_pal <= '0;
        miss     <= 1'b0;
      end else if (boundary) begin
        prev     <= cur;
        prev_pal <= cur_pal;
        cur      <= pend;
        cur_pal  <= pend_pal;
        fresh    <= 1'b0;
        if (!fresh) miss <= 1'b1;
      end
      if (load) begin
        pend     <= row;
        pend_pal <= pal;
        fresh    <= 1'b1;
      end
    end
  end

  // Index is 1..15 for any phase/fine pair, so no wrap handling is needed.
  assign win     = {cur, prev};
  assign idx     = 4'd8 + {1'b0, phase} - {1'b0, fine};
  assign pix     = win[idx];
  assign pix_pal = idx[3] ? cur_pal : prev_pal;
endmodule

// File: rtl/k051962_plane_shifter.sv
// Serialises fix/A/B tile rows into pixels and resolves plane priority.
module k051962_plane_shifter
  import k051962_pkg::*;
(
  input  logic        clk_24M,
  input  logic        RES,
  input  logic        CE_PIX,
  input  logic        LINE_START,
  input  logic [2:0]  LOAD,
  input  logic [31:0] ROM_D,
  input  logic [7:0]  COL,
  input  logic [2:0]  ZA,
  input  logic [2:0]  ZB,
  input  logic        PRIO,
  output logic [7:0]  COLOR,
  output logic [1:0]  LAYER,
  output logic [2:0]  TILE_MISS
);
  logic [2:0] phase;
  logic       boundary;
  row_t       row;

  pix4_t [NPLANES-1:0]      pix;
  logic  [NPLANES-1:0][3:0] pix_pal;
  logic  [NPLANES-1:0][2:0] fine;
  logic  [NPLANES-1:0]      miss;

  logic [1:0] first, second;
  logic [7:0] nxt_color;
  logic [1:0] nxt_layer;

  assign boundary = (phase == 3'd7) | LINE_START;
  assign row      = unpack_row(ROM_D, COL[0]);

  assign fine[PL_FIX] = 3'd0;
  assign fine[PL_A]   = ZA;
  assign fine[PL_B]   = ZB;

  for (genvar p = 0; p < NPLANES; p++) begin : g_plane
    plane_window u_win (
      .clk        (clk_24M),
      .rst        (RES),
      .ce         (CE_PIX),
      .line_start (LINE_START),
      .boundary   (boundary),
      .load       (LOAD[p]),
      .row        (row),
      .pal        (COL[7:4]),
      .fine       (fine[p]),
      .phase      (phase),
      .pix        (pix[p]),
      .pix_pal    (pix_pal[p]),
      .miss       (miss[p])
    );
  end

  always_comb begin
    first     = PRIO ? PL_B : PL_A;
    second    = PRIO ? PL_A : PL_B;
    nxt_color = 8'h00;
    nxt_layer = LAYER_NONE;
    if (pix[PL_FIX] != 4'd0) begin
      nxt_color = {pix_pal[PL_FIX], pix[PL_FIX]};
      nxt_layer = PL_FIX;
    end else if (pix[first] != 4'd0) begin
      nxt_color = {pix_pal[first], pix[first]};
      nxt_layer = first;
    end else if (pix[second] != 4'd0) begin
      nxt_color = {pix_pal[second], pix[second]};
      nxt_layer = second;
    end
  end

  always_ff @(posedge clk_24M) begin
    if (RES) begin
      phase <= 3'd0;
      COLOR <= 8'h00;
      LAYER <= LAYER_NONE;
    end else if (CE_PIX) begin
      phase <= LINE_START ? 3'd0 : phase + 3'd1;
      COLOR <= nxt_color;
      LAYER <= nxt_layer;
    end
  end

  assign TILE_MISS = miss;
endmodule
